// File: rtl/bus_fifo_pkg.sv
// rtl/bus_fifo_pkg.sv - shared defaults, pointer width helper and pointer type for the bus byte FIFO
package bus_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  typedef logic [clog2_f(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/bus_fifo_ram.sv
// rtl/bus_fifo_ram.sv - DEPTH x WIDTH storage, one synchronous write port, one registered read port
module bus_fifo_ram
  import bus_fifo_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not cleared by reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bus_fifo8.sv
// rtl/bus_fifo8.sv - 16x8 synchronous byte FIFO with registered read and one-cycle valid strobe
// Optional sticky overflow/underflow outputs are enabled by defining BUS_FIFO_ERR_EN.
module bus_fifo8
  import bus_fifo_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
`ifdef BUS_FIFO_ERR_EN
  output logic              ovf,
  output logic              unf,
`endif
  output logic [ADDR_W:0]   count
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              wr_acc;
  logic              rd_acc;

  assign full   = (count == (ADDR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  // A full FIFO still accepts a write when a read frees the slot in the same cycle.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + (ADDR_W+1)'(1);
      2'b01:   count_next = count - (ADDR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      count    <= count_next;
      rd_valid <= rd_acc;
    end
  end

`ifdef BUS_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wr_en & full & ~rd_en) ovf <= 1'b1;
      if (rd_en & empty)         unf <= 1'b1;
    end
  end
`endif

  bus_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_bus_fifo8.sv
// tb/tb_bus_fifo8.sv - directed and randomized checks of bus_fifo8 against a queue-based reference
module tb_bus_fifo8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [4:0] count;
`ifdef BUS_FIFO_ERR_EN
  logic       ovf;
  logic       unf;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_ovf;
  logic       exp_unf;

  always #5 clk = ~clk;

  bus_fifo8 dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
`ifdef BUS_FIFO_ERR_EN
    .ovf      (ovf),
    .unf      (unf),
`endif
    .count    (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " rd_valid"}, {31'd0, rd_valid}, {31'd0, exp_valid});
    chk({tag, " rd_data"}, {24'd0, rd_data}, {24'd0, exp_data});
    chk({tag, " count"}, {27'd0, count}, q.size());
    chk({tag, " full"}, {31'd0, full}, {31'd0, q.size() == 16});
    chk({tag, " empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
`ifdef BUS_FIFO_ERR_EN
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    chk({tag, " unf"}, {31'd0, unf}, {31'd0, exp_unf});
`endif
  endtask

  task automatic step(input logic w, input logic [7:0] wd, input logic r, input string tag);
    bit was_full, was_empty;
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    wr_en = w; wr_data = wd; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (w && was_full && !r) exp_ovf = 1'b1;
    if (r && was_empty) exp_unf = 1'b1;
    if (r && !was_empty) begin
      exp_data  = q.pop_front();
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (w && (!was_full || r)) q.push_back(wd);
    chk_model(tag);
  endtask

  task automatic do_reset(input int cycles, input logic r);
    rst = 1'b1; rd_en = r; wr_en = r;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    q.delete();
    exp_data = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  initial begin
    logic [7:0] b;

    do_reset(2, 1'b0);
    chk_model("reset");
    chk("reset count", {27'd0, count}, 32'd0);

    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, "fill");
    chk("fill full", {31'd0, full}, 32'd1);
    chk("fill count", {27'd0, count}, 32'd16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, "drain");
      chk("drain order", {24'd0, rd_data}, i);
    end
    chk("drain empty", {31'd0, empty}, 32'd1);

    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, "refill");
    step(1'b1, 8'hAA, 1'b1, "full wr+rd");
    chk("full wr+rd data", {24'd0, rd_data}, 32'h01);
    chk("full wr+rd count", {27'd0, count}, 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, "post-full drain");
    chk("aa after 16 reads", {24'd0, rd_data}, 32'hAA);

    step(1'b1, 8'h55, 1'b1, "empty wr+rd");
    chk("empty wr+rd valid", {31'd0, rd_valid}, 32'd0);
    chk("empty wr+rd count", {27'd0, count}, 32'd1);
    step(1'b0, 8'h00, 1'b1, "read 55");
    chk("read 55 data", {24'd0, rd_data}, 32'h55);

    b = 8'h00;
    for (int i = 0; i < 3; i++) begin step(1'b1, b, 1'b0, "wrap prime"); b++; end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, b, 1'b1, "wrap");
      chk("wrap count", {27'd0, count}, 32'd3);
      b++;
    end

    for (int i = 0; i < 2; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, "to five");
    chk("count five", {27'd0, count}, 32'd5);
    do_reset(1, 1'b1);
    chk_model("mid reset");
    chk("mid reset valid", {31'd0, rd_valid}, 32'd0);
    chk("mid reset count", {27'd0, count}, 32'd0);

    for (int i = 0; i < 17; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, "write17");
    chk("write17 count", {27'd0, count}, 32'd16);
`ifdef BUS_FIFO_ERR_EN
    chk("write17 ovf", {31'd0, ovf}, 32'd1);
`endif
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, "drain17");
    chk("last kept byte", {24'd0, rd_data}, 32'h8F);
    step(1'b0, 8'h00, 1'b1, "underflow");
    do_reset(1, 1'b0);
    chk_model("post reset");

    for (int i = 0; i < 600; i++) begin
      logic w, r;
      w = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 35 : 70));
      step(w, 8'($urandom), r, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
